// File: rtl/player_motion_pkg.sv
// Shared constants and state encoding for the player kinematics stage,
// also consumed by the controllers and the ball logic.
package player_motion_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_SMASH  = 2'd2
  } motion_state_e;

  localparam int unsigned POS_W          = 10;
  localparam int unsigned DEF_GROUND_Y   = 320;
  localparam int unsigned NET_X          = 320;
  localparam int unsigned LEFT_X_MIN     = 10;
  localparam int unsigned LEFT_X_MAX     = 290;
  localparam int unsigned RIGHT_X_MIN    = 350;
  localparam int unsigned RIGHT_X_MAX    = 630;

  // Encoding 3 is unused and treated as standing on the ground.
  function automatic logic is_airborne(input logic [1:0] st);
    return (st == ST_AIR) || (st == ST_SMASH);
  endfunction

endpackage

// File: rtl/player_motion_if.sv
// Controller command bits in, kinematic state out; master = controller side.
interface player_motion_if;
  import player_motion_pkg::*;

  logic             frame_tick;
  logic             move_left;
  logic             move_right;
  logic             jump;
  logic             smash;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic             airborne;
  logic             smash_active;
  logic [1:0]       state;

  modport master (
    output frame_tick, move_left, move_right, jump, smash,
    input  pos_x, pos_y, airborne, smash_active, state
  );

  modport slave (
    input  frame_tick, move_left, move_right, jump, smash,
    output pos_x, pos_y, airborne, smash_active, state
  );
endinterface

// File: rtl/player_vert_integrator.sv
// Vertical position/velocity integration with landing detect.
// Velocity is signed, positive meaning upward (screen y decreasing).
module player_vert_integrator #(
  parameter int GROUND_Y = 320,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       active,
  input  logic       launch,
  output logic [9:0] pos_y,
  output logic       land
);

  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [7:0]  V0       = 8'(JUMP_V0);
  localparam logic signed [7:0]  G        = 8'(GRAVITY);

  logic [9:0]         pos_y_q, pos_y_d;
  logic signed [7:0]  vel_y_q, vel_y_d;
  logic signed [10:0] next_y;

  assign next_y = $signed({1'b0, pos_y_q}) - $signed({{3{vel_y_q[7]}}, vel_y_q});
  assign land   = active && (next_y >= GROUND_S);
  assign pos_y  = pos_y_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pos_y_d = pos_y_q;
    vel_y_d = vel_y_q;
    if (tick) begin
      if (launch) begin
        vel_y_d = V0;
      end else if (active) begin
        if (land) begin
          pos_y_d = 10'(GROUND_Y);
          vel_y_d = '0;
        end else begin
          pos_y_d = next_y[9:0];
          vel_y_d = vel_y_q - G;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_y_q <= 10'(GROUND_Y);
      vel_y_q <= '0;
    end else begin
      pos_y_q <= pos_y_d;
      vel_y_q <= vel_y_d;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-player kinematics: ground/air/smash FSM, clamped horizontal motion and
// smash/cooldown counters; vertical motion lives in player_vert_integrator.
module player_motion
  import player_motion_pkg::*;
#(
  parameter int START_X        = 60,
  parameter int GROUND_Y       = 320,
  parameter int X_MIN          = 10,
  parameter int X_MAX          = 290,
  parameter int STEP_X         = 3,
  parameter int JUMP_V0        = 12,
  parameter int GRAVITY        = 1,
  parameter int SMASH_FRAMES   = 8,
  parameter int SMASH_COOLDOWN = 16
) (
  input  logic           clk,
  input  logic           rst,
  player_motion_if.slave bus
);

  localparam int SC_W = $clog2(SMASH_FRAMES + 1);
  localparam int CD_W = $clog2(SMASH_COOLDOWN + 1);

  motion_state_e   state_q, state_d;
  logic [9:0]      pos_x_q, pos_x_d;
  logic [SC_W-1:0] smash_cnt_q, smash_cnt_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic [10:0]     x_wide;
  logic            in_air;
  logic            launch;
  logic            land;
  logic [9:0]      pos_y;

  assign in_air = is_airborne(state_q);

  player_vert_integrator #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V0  (JUMP_V0),
    .GRAVITY  (GRAVITY)
  ) u_vert (
    .clk    (clk),
    .rst    (rst),
    .tick   (bus.frame_tick),
    .active (in_air),
    .launch (launch),
    .pos_y  (pos_y),
    .land   (land)
  );

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    smash_cnt_d = smash_cnt_q;
    cooldown_d  = cooldown_q;
    launch      = 1'b0;
    x_wide      = {1'b0, pos_x_q};

    if (bus.frame_tick) begin
      if (cooldown_q != '0) cooldown_d = cooldown_q - 1'b1;

      // 11-bit arithmetic keeps the left clamp from wrapping near zero.
      if (state_q != ST_SMASH) begin
        if (bus.move_left && !bus.move_right) begin
          pos_x_d = (x_wide < 11'(X_MIN + STEP_X)) ? 10'(X_MIN) : 10'(x_wide - 11'(STEP_X));
        end else if (bus.move_right && !bus.move_left) begin
          x_wide  = {1'b0, pos_x_q} + 11'(STEP_X);
          pos_x_d = (x_wide > 11'(X_MAX)) ? 10'(X_MAX) : x_wide[9:0];
        end
      end

      case (state_q)
        ST_AIR: begin
          if (land) begin
            state_d = ST_GROUND;
          end else if (bus.smash && (cooldown_q == '0)) begin
            state_d     = ST_SMASH;
            smash_cnt_d = SC_W'(SMASH_FRAMES);
          end
        end
        ST_SMASH: begin
          if (land) begin
            state_d     = ST_GROUND;
            smash_cnt_d = '0;
            cooldown_d  = CD_W'(SMASH_COOLDOWN);
          end else begin
            smash_cnt_d = smash_cnt_q - 1'b1;
            if (smash_cnt_q == SC_W'(1)) begin
              state_d    = ST_AIR;
              cooldown_d = CD_W'(SMASH_COOLDOWN);
            end
          end
        end
        default: begin
          // Smash is ignored on the ground, even together with jump.
          if (bus.jump) begin
            launch  = 1'b1;
            state_d = ST_AIR;
          end else begin
            state_d = ST_GROUND;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_GROUND;
      pos_x_q     <= 10'(START_X);
      smash_cnt_q <= '0;
      cooldown_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      smash_cnt_q <= smash_cnt_d;
      cooldown_q  <= cooldown_d;
    end
  end

  assign bus.pos_x        = pos_x_q;
  assign bus.pos_y        = pos_y;
  assign bus.airborne     = in_air;
  assign bus.smash_active = (state_q == ST_SMASH);
  assign bus.state        = state_q;

endmodule

// File: doc/player_motion.md
# player_motion

Per-player kinematics stage sitting directly downstream of the player controllers (keyboard or computer player): it consumes the move_left / move_right / jump / smash command bits once per video frame and integrates them into the player's on-screen position, jump arc and smash pose. Its pos_x / pos_y outputs feed the renderer and the ball-collision logic, and loop back to the computer player as its own-position inputs. One instance per player; parameters select the court half.

## Interface
Parameters:
- START_X, 60: x position after reset.
- GROUND_Y, 320: standing y (screen y grows downward).
- X_MIN, 10 / X_MAX, 290: horizontal clamp limits (left half; net at 320).
- STEP_X, 3: horizontal pixels per frame.
- JUMP_V0, 12: initial upward velocity, px/frame.
- GRAVITY, 1: velocity decrement per frame.
- SMASH_FRAMES, 8: frames the smash pose lasts.
- SMASH_COOLDOWN, 16: frames before another smash may start.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; all state advances only on it.
- move_left, move_right, jump, smash  in  1 each  controller commands, level-sensitive, sampled at frame_tick.
- pos_x  out  10  player x, unsigned pixels.
- pos_y  out  10  player y, unsigned pixels.
- airborne  out  1  high in AIR or SMASH.
- smash_active  out  1  high in SMASH; enlarges hit box in ball logic.
- state  out  2  GROUND=0, AIR=1, SMASH=2 (3 unused, decodes as GROUND).

## Operation
- Reset values: pos_x=START_X, pos_y=GROUND_Y, vel_y=0, state=GROUND, smash and cooldown counters 0, airborne=0, smash_active=0.
- Without frame_tick all registers hold.
- Horizontal (GROUND, AIR): left only → pos_x=max(pos_x−STEP_X, X_MIN); right only → min(pos_x+STEP_X, X_MAX); both or neither → hold. Compute in 11 bits to avoid underflow. SMASH freezes x.
- GROUND: jump=1 → vel_y=JUMP_V0, state AIR; pos_y unchanged this tick. smash ignored on ground, including same tick as jump.
- AIR/SMASH vertical, each tick: next_y = pos_y − vel_y (11-bit signed); vel_y −= GRAVITY (8-bit signed, positive = up). If next_y ≥ GROUND_Y: pos_y=GROUND_Y, vel_y=0, state GROUND.
- AIR: smash=1 and cooldown=0 and no landing this tick → state SMASH, smash_cnt=SMASH_FRAMES.
- SMASH: smash_cnt decrements each tick; at reaching 0 → AIR, cooldown=SMASH_COOLDOWN. Landing while in SMASH takes priority: → GROUND, cooldown=SMASH_COOLDOWN.
- Cooldown decrements every tick (saturating at 0) in all states except the tick it is loaded.
- Jump held through landing: re-jump on the next tick after GROUND entry (auto-bounce permitted).

## Timing
- Inputs sampled on the clk edge where frame_tick=1; all outputs registered, valid the following cycle, stable for the rest of the frame.
- Default arc: apex y=242 after 12 ticks (holds at 13), lands at y=320 exactly on tick 25 after the jump tick.
- Async rst at any time (mid-air, mid-smash) forces reset values immediately; first update on the first frame_tick after release.

## Structure
- Shared package: state encoding, GROUND_Y, NET_X, default court limits; also used by the controllers and ball logic.
- One sub-module: player_vert_integrator (pos_y / vel_y update plus landing detect); the FSM, x clamp and counters stay in the top.

## Test plan
- Reset, hold move_right 100 ticks → pos_x 60→63→…, saturates at 290; both left+right held → x unchanged.
- Jump one tick from GROUND → pos_y 320, 308, 297, …, 242 at tick 12, 320 with state=GROUND at tick 25; airborne high ticks 1–24.
- Smash at tick 3 of jump → smash_active high 8 ticks, pos_x frozen, then AIR; second smash within 16 ticks ignored.
- Smash at tick 20 → landing at tick 25 cuts SMASH short, state GROUND, cooldown loaded.
- Jump+smash same tick on ground → AIR only, smash_active stays 0; jump held continuously → re-jump on the tick after landing.
- Assert rst at tick 15 mid-air → pos_x=60, pos_y=320, state=0 immediately; no movement until next frame_tick.
